// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard and sequencing control for the 5-stage MIPS core.
// Drives per-stage stall/flush controls and the ID/EX forwarding selects.
// Hazard sources: load-use, branch/jump-register operand hazards, a
// multi-cycle divider (D_IDLE/D_BUSY/D_DONE), a data-memory wait FSM
// (M_IDLE/M_WAIT) and exception flush from the ME stage.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rsD/rtD, rsE/rtE                 ID / EX source registers
//   writeregE/M/W, regwriteE/M/W     destination register and write enable per stage
//   memtoregE/M                      stage holds a load
//   branchD, jumpregD                ID reads registers for control flow
//   isdivE                           EX holds DIV/DIVU
//   exceptM                          exception or ERET taken in ME
//   dmem_reqM, dmem_ack              data-memory request valid / request complete
//   forwardaD/bD                     ID forward from ME
//   forwardaE/bE                     EX operand select: 00 regfile, 01 WB, 10 ME
//   stallF..stallW, flushD..flushW   pipeline register hold / clear
//   div_startE                       one-cycle divider start pulse
module hazard_unit #(
  parameter int unsigned DIV_CYCLES = 36
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jumpregD,
  input  logic       isdivE,
  input  logic       exceptM,
  input  logic       dmem_reqM,
  input  logic       dmem_ack,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       div_startE
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_BUSY = 2'd1,
    D_DONE = 2'd2
  } divState_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } memState_t;

  divState_t        divState, divNext;
  memState_t        memState, memNext;
  logic [CNT_W-1:0] cnt, cntNext;

  logic memStall, divStall, lwStall, branchStall;
  logic stallEraw;

  // Raw hazard terms
  assign memStall    = dmem_reqM & ~dmem_ack & ~exceptM;
  assign divStall    = ((divState == D_IDLE) & isdivE & ~exceptM) | (divState == D_BUSY);
  assign lwStall     = memtoregE & ((rtE == rsD) | (rtE == rtD));
  assign branchStall = (branchD | jumpregD) &
                       ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                        (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
  assign stallEraw   = (memStall | divStall) & ~exceptM;

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      divState <= D_IDLE;
      memState <= M_IDLE;
      cnt      <= '0;
    end else begin
      divState <= divNext;
      memState <= memNext;
      cnt      <= cntNext;
    end
  end

  // Next-state logic and outputs
  always_comb begin
    divNext    = divState;
    memNext    = memState;
    cntNext    = cnt;
    forwardaD  = 1'b0;
    forwardbD  = 1'b0;
    forwardaE  = 2'b00;
    forwardbE  = 2'b00;
    stallF     = 1'b0;
    stallD     = 1'b0;
    stallE     = 1'b0;
    stallM     = 1'b0;
    stallW     = 1'b0;
    flushD     = 1'b0;
    flushE     = 1'b0;
    flushM     = 1'b0;
    flushW     = 1'b0;
    div_startE = 1'b0;

    // Divider sequencing: the issue cycle plus DIV_CYCLES-2 busy cycles are
    // stalled, then D_DONE lets EX advance, for DIV_CYCLES cycles in total.
    if (exceptM) begin
      divNext = D_IDLE;
      cntNext = '0;
    end else begin
      unique case (divState)
        D_IDLE: begin
          if (isdivE && !memStall) begin
            div_startE = 1'b1;
            if (DIV_CYCLES > 2) begin
              divNext = D_BUSY;
              cntNext = CNT_W'(DIV_CYCLES - 2);
            end else begin
              divNext = D_DONE;
            end
          end
        end
        D_BUSY: begin
          if (cnt <= CNT_W'(1)) begin
            divNext = D_DONE;
            cntNext = '0;
          end else begin
            cntNext = cnt - CNT_W'(1);
          end
        end
        D_DONE:  divNext = D_IDLE;
        default: divNext = D_IDLE;
      endcase
    end

    // Data-memory handshake tracking
    if (exceptM) begin
      memNext = M_IDLE;
    end else begin
      unique case (memState)
        M_IDLE:  if (dmem_reqM && !dmem_ack) memNext = M_WAIT;
        M_WAIT:  if (dmem_ack) memNext = M_IDLE;
        default: memNext = M_IDLE;
      endcase
    end

    if (rst) begin
      div_startE = 1'b0;
    end else begin
      // Register 0 is never forwarded; ME beats WB
      forwardaD = (rsD != 5'd0) & regwriteM & (rsD == writeregM);
      forwardbD = (rtD != 5'd0) & regwriteM & (rtD == writeregM);

      if ((rsE != 5'd0) && regwriteM && (rsE == writeregM))      forwardaE = 2'b10;
      else if ((rsE != 5'd0) && regwriteW && (rsE == writeregW)) forwardaE = 2'b01;

      if ((rtE != 5'd0) && regwriteM && (rtE == writeregM))      forwardbE = 2'b10;
      else if ((rtE != 5'd0) && regwriteW && (rtE == writeregW)) forwardbE = 2'b01;

      // Exception overrides every stall
      if (!exceptM) begin
        stallW = memStall;
        stallM = memStall;
        stallE = stallEraw;
        stallD = stallEraw | lwStall | branchStall;
        stallF = stallEraw | lwStall | branchStall;
      end

      flushD = exceptM;
      flushW = exceptM;
      flushE = exceptM | ((lwStall | branchStall) & ~stallEraw);
      // M is held rather than bubbled when memory is also stalling
      flushM = exceptM | (divStall & ~memStall);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios for hazard_unit with a scoreboard of
// expected output vectors, compared half a cycle after each drive.
module tb_hazard_unit;

  localparam int unsigned DIVC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jumpregD, isdivE, exceptM, dmem_reqM, dmem_ack;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW, div_startE;

  logic [15:0] outs;
  logic [15:0] sb[$];
  logic [15:0] want;
  int          nChecks = 0;
  int          nPass   = 0;

  hazard_unit #(.DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jumpregD(jumpregD), .isdivE(isdivE), .exceptM(exceptM),
    .dmem_reqM(dmem_reqM), .dmem_ack(dmem_ack),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_startE(div_startE)
  );

  always #5 clk = ~clk;

  assign outs = {forwardaD, forwardbD, forwardaE, forwardbE,
                 stallF, stallD, stallE, stallM, stallW,
                 flushD, flushE, flushM, flushW, div_startE};

  // Expected vector: st = {F,D,E,M,W}, fl = {D,E,M,W}
  function automatic logic [15:0] mk(input logic faD, input logic fbD,
                                     input logic [1:0] faE, input logic [1:0] fbE,
                                     input logic [4:0] st, input logic [3:0] fl,
                                     input logic start);
    return {faD, fbD, faE, fbE, st, fl, start};
  endfunction

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0; branchD = 0; jumpregD = 0;
    isdivE = 0; exceptM = 0; dmem_reqM = 0; dmem_ack = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clr();
      if (i < 2) begin
        rst = 1'b1; isdivE = 1; dmem_reqM = 1; regwriteM = 1; writeregM = 3;
        rsE = 3; rtE = 3; rsD = 3; rtD = 3; memtoregE = 1; branchD = 1;
      end else begin
        rst = 1'b0;
      end
      sb.push_back(16'h0000);
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL reset step %0d: got %b want %b", i, outs, want);
      else nPass++;
      if (i == 1) begin
        nChecks++;
        if (dut.divState !== 2'd0 || dut.memState !== 1'b0)
          $display("FAIL reset_state: got div=%0d mem=%0d want 0/0", dut.divState, dut.memState);
        else nPass++;
      end
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clr();
      regwriteW = 1; writeregW = 3; regwriteM = 1; writeregM = 3;
      rsE = 3; rtE = 3; rsD = 3;
      case (i)
        0: sb.push_back(mk(1, 0, 2'b10, 2'b10, 5'b0, 4'b0, 0));
        1: begin regwriteM = 0; sb.push_back(mk(0, 0, 2'b01, 2'b01, 5'b0, 4'b0, 0)); end
        2: begin regwriteM = 0; rsE = 0; sb.push_back(mk(0, 0, 2'b00, 2'b01, 5'b0, 4'b0, 0)); end
        default: begin
          writeregW = 0; writeregM = 0; rsE = 0; rtE = 0; rsD = 0;
          sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b0, 4'b0, 0));
        end
      endcase
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL forward step %0d: got %b want %b", i, outs, want);
      else nPass++;
    end
  endtask

  task automatic test_lwstall();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clr();
      if (i == 0) begin
        memtoregE = 1; regwriteE = 1; writeregE = 4; rtE = 4; rsD = 7; rtD = 4;
        sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11000, 4'b0100, 0));
      end else begin
        regwriteW = 1; writeregW = 4; rtE = 4;
        sb.push_back(mk(0, 0, 2'b00, 2'b01, 5'b0, 4'b0, 0));
      end
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL lwstall step %0d: got %b want %b", i, outs, want);
      else nPass++;
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clr();
      case (i)
        0: begin
          branchD = 1; rsD = 5; rtD = 9; regwriteE = 1; writeregE = 5;
          sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11000, 4'b0100, 0));
        end
        1: begin
          branchD = 1; rsD = 5; rtD = 9; regwriteM = 1; writeregM = 5;
          sb.push_back(mk(1, 0, 2'b00, 2'b00, 5'b0, 4'b0, 0));
        end
        2: begin
          jumpregD = 1; rsD = 2; rtD = 6; memtoregM = 1; regwriteM = 1; writeregM = 6;
          sb.push_back(mk(0, 1, 2'b00, 2'b00, 5'b11000, 4'b0100, 0));
        end
        default: begin
          rsD = 2; rtD = 6; memtoregM = 1; regwriteM = 1; writeregM = 6;
          sb.push_back(mk(0, 1, 2'b00, 2'b00, 5'b0, 4'b0, 0));
        end
      endcase
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL branch step %0d: got %b want %b", i, outs, want);
      else nPass++;
    end
  endtask

  // Two back-to-back DIVs: issue + 2 busy stalled, then one free cycle each
  task automatic test_div();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clr();
      isdivE = (i < 8);
      if (i == 8 || (i % 4) == 3) sb.push_back(16'h0000);
      else sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11100, 4'b0010, ((i % 4) == 0)));
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL div step %0d: got %b want %b", i, outs, want);
      else nPass++;
    end
    nChecks++;
    if (dut.divState !== 2'd0) $display("FAIL div_idle: got %0d want 0", dut.divState);
    else nPass++;
  endtask

  task automatic test_memwait();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clr();
      if (i < 3) begin
        dmem_reqM = 1;
        sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11111, 4'b0, 0));
      end else if (i == 3 || i == 5) begin
        dmem_reqM = 1; dmem_ack = 1;
        sb.push_back(16'h0000);
      end else begin
        sb.push_back(16'h0000);
      end
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL memwait step %0d: got %b want %b", i, outs, want);
      else nPass++;
      if (i == 1 || i == 4 || i == 6) begin
        nChecks++;
        if (dut.memState !== (i == 1))
          $display("FAIL memwait_state step %0d: got %0d want %0d", i, dut.memState, (i == 1));
        else nPass++;
      end
    end
  endtask

  // Memory wait overlapping a DIV issue: no start and no M bubble until ack
  task automatic test_mem_div();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clr();
      isdivE = 1;
      case (i)
        0: begin dmem_reqM = 1; sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11111, 4'b0000, 0)); end
        1: begin dmem_reqM = 1; dmem_ack = 1; sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11100, 4'b0010, 1)); end
        2, 3: sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11100, 4'b0010, 0));
        default: sb.push_back(16'h0000);
      endcase
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL mem_div step %0d: got %b want %b", i, outs, want);
      else nPass++;
    end
  endtask

  task automatic test_except();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clr();
      case (i)
        0: begin isdivE = 1; sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11100, 4'b0010, 1)); end
        1, 3: begin
          isdivE = 1; exceptM = 1; dmem_reqM = 1;
          sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b0, 4'b1111, 0));
        end
        default: sb.push_back(16'h0000);
      endcase
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL except step %0d: got %b want %b", i, outs, want);
      else nPass++;
      if (i == 2 || i == 4) begin
        nChecks++;
        if (dut.divState !== 2'd0 || dut.memState !== 1'b0)
          $display("FAIL except_state step %0d: got div=%0d mem=%0d want 0/0", i, dut.divState, dut.memState);
        else nPass++;
      end
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      clr();
      rst = 1'b0;
      case (i)
        0: begin isdivE = 1; sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11100, 4'b0010, 1)); end
        1: begin isdivE = 1; sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11100, 4'b0010, 0)); end
        2, 5: begin rst = 1'b1; isdivE = 1; dmem_reqM = 1; sb.push_back(16'h0000); end
        4: begin dmem_reqM = 1; sb.push_back(mk(0, 0, 2'b00, 2'b00, 5'b11111, 4'b0, 0)); end
        default: sb.push_back(16'h0000);
      endcase
      #1;
      want = sb.pop_front();
      nChecks++;
      if (outs !== want) $display("FAIL rst_mid step %0d: got %b want %b", i, outs, want);
      else nPass++;
      if (i == 3 || i == 6) begin
        nChecks++;
        if (dut.divState !== 2'd0 || dut.memState !== 1'b0)
          $display("FAIL rst_mid_state step %0d: got div=%0d mem=%0d want 0/0", i, dut.divState, dut.memState);
        else nPass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clr();
    test_reset();
    test_forward();
    test_lwstall();
    test_branch();
    test_div();
    test_memwait();
    test_mem_div();
    test_except();
    test_rst_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
